// File: rtl/la_capture_ctrl_if.sv
// Capture-sequencer bus: arming/trigger configuration in, SRAM gating and status out.
// master drives configuration and samples status; slave is the sequencer.
interface la_capture_ctrl_if #(
  parameter int unsigned LA_WIDTH  = 8,
  parameter int unsigned LA_CHIPS  = 2,
  parameter int unsigned CNT_WIDTH = 23
);
  logic                 start;
  logic                 abort;
  logic [CNT_WIDTH-1:0] pre_samples;
  logic [CNT_WIDTH-1:0] post_samples;
  logic [LA_WIDTH-1:0]  trig_mask;
  logic [LA_WIDTH-1:0]  trig_value;
  logic [LA_WIDTH-1:0]  edge_mask;
  logic [LA_WIDTH-1:0]  edge_rise;
  logic [LA_WIDTH-1:0]  la_in;
  logic                 sample_en;
  logic [LA_CHIPS-1:0]  sram_cs;
  logic                 busy;
  logic                 triggered;
  logic                 done;
  logic                 wrapped;
  logic [CNT_WIDTH-1:0] sample_index;
  logic [CNT_WIDTH-1:0] trig_index;

  modport master (
    output start, abort, pre_samples, post_samples, trig_mask, trig_value,
           edge_mask, edge_rise, la_in,
    input  sample_en, sram_cs, busy, triggered, done, wrapped, sample_index, trig_index
  );

  modport slave (
    input  start, abort, pre_samples, post_samples, trig_mask, trig_value,
           edge_mask, edge_rise, la_in,
    output sample_en, sram_cs, busy, triggered, done, wrapped, sample_index, trig_index
  );
endinterface

// File: rtl/la_capture_ctrl.sv
// Logic-analyzer capture sequencer: pre-trigger fill, level/edge trigger, post-trigger fill
// into a ring buffer of DEPTH samples, with SRAM clock gating and chip-select control.
module la_capture_ctrl #(
  parameter int unsigned LA_WIDTH  = 8,
  parameter int unsigned LA_CHIPS  = 2,
  parameter int unsigned CNT_WIDTH = 23,
  parameter int unsigned DEPTH     = 2 ** CNT_WIDTH
) (
  input logic              clock,
  input logic              reset_n,
  la_capture_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_WAIT,
    S_POST,
    S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] idx_q, idx_d;
  logic [CNT_WIDTH-1:0] trig_idx_q, trig_idx_d;
  logic [LA_WIDTH-1:0]  la_prev_q, la_prev_d;
  logic [LA_CHIPS-1:0]  cs_q, cs_d;
  logic                 sample_en_q, sample_en_d;
  logic                 busy_q, busy_d;
  logic                 triggered_q, triggered_d;
  logic                 done_q, done_d;
  logic                 wrapped_q, wrapped_d;
  logic                 finish;

  logic                 capturing;
  logic                 idx_last;
  logic [CNT_WIDTH-1:0] cnt_inc;
  logic [LA_WIDTH-1:0]  edge_hit;
  logic                 level_ok;
  logic                 edge_ok;
  logic                 trig_hit;

  assign capturing = (state_q == S_PRE) || (state_q == S_WAIT) || (state_q == S_POST);
  assign idx_last  = (idx_q == CNT_WIDTH'(DEPTH - 1));
  assign cnt_inc   = cnt_q + 1'b1;

  // Per-channel edge detect against the previous sample; unmasked channels always pass.
  assign edge_hit = (bus.edge_rise & ~la_prev_q & bus.la_in) |
                    (~bus.edge_rise & la_prev_q & ~bus.la_in);
  assign level_ok = (((bus.la_in ^ bus.trig_value) & bus.trig_mask) == '0);
  assign edge_ok  = ((~edge_hit & bus.edge_mask) == '0);
  assign trig_hit = level_ok && edge_ok;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      trig_idx_q  <= '0;
      la_prev_q   <= '0;
      cs_q        <= '1;
      sample_en_q <= 1'b0;
      busy_q      <= 1'b0;
      triggered_q <= 1'b0;
      done_q      <= 1'b0;
      wrapped_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      trig_idx_q  <= trig_idx_d;
      la_prev_q   <= la_prev_d;
      cs_q        <= cs_d;
      sample_en_q <= sample_en_d;
      busy_q      <= busy_d;
      triggered_q <= triggered_d;
      done_q      <= done_d;
      wrapped_q   <= wrapped_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    trig_idx_d  = trig_idx_q;
    la_prev_d   = la_prev_q;
    cs_d        = cs_q;
    sample_en_d = sample_en_q;
    busy_d      = busy_q;
    triggered_d = triggered_q;
    done_d      = done_q;
    wrapped_d   = wrapped_q;
    finish      = 1'b0;

    if (bus.abort) begin
      // Abort wins over start and trigger; capture position and trigger info are kept.
      state_d     = S_IDLE;
      sample_en_d = 1'b0;
      cs_d        = '1;
      busy_d      = 1'b0;
      done_d      = 1'b0;
    end else begin
      if (capturing) begin
        la_prev_d = bus.la_in;
        if (idx_last) begin
          idx_d     = '0;
          wrapped_d = 1'b1;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end

      case (state_q)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            state_d     = (bus.pre_samples == '0) ? S_WAIT : S_PRE;
            cnt_d       = '0;
            idx_d       = '0;
            triggered_d = 1'b0;
            done_d      = 1'b0;
            wrapped_d   = 1'b0;
            la_prev_d   = bus.la_in;
            sample_en_d = 1'b1;
            cs_d        = '0;
            busy_d      = 1'b1;
          end
        end
        S_PRE: begin
          if (cnt_inc == bus.pre_samples) begin
            state_d = S_WAIT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        S_WAIT: begin
          if (trig_hit) begin
            trig_idx_d  = idx_q;
            triggered_d = 1'b1;
            cnt_d       = '0;
            if (bus.post_samples == '0) finish = 1'b1;
            else                        state_d = S_POST;
          end
        end
        S_POST: begin
          if (cnt_inc == bus.post_samples) finish = 1'b1;
          else                             cnt_d = cnt_inc;
        end
        default: state_d = S_IDLE;
      endcase

      // The edge that takes the last sample also closes the SRAM window.
      if (finish) begin
        state_d     = S_DONE;
        sample_en_d = 1'b0;
        cs_d        = '1;
        busy_d      = 1'b0;
        done_d      = 1'b1;
      end
    end
  end

  assign bus.sample_en    = sample_en_q;
  assign bus.sram_cs      = cs_q;
  assign bus.busy         = busy_q;
  assign bus.triggered    = triggered_q;
  assign bus.done         = done_q;
  assign bus.wrapped      = wrapped_q;
  assign bus.sample_index = idx_q;
  assign bus.trig_index   = trig_idx_q;

endmodule

// File: tb/tb_la_capture_ctrl.sv
// Bench for la_capture_ctrl: directed scenarios plus randomized captures checked
// against a sample-by-sample trigger search over the stimulus sequence.
module tb_la_capture_ctrl;
  localparam int unsigned LW    = 8;
  localparam int unsigned LC    = 2;
  localparam int unsigned CW    = 23;
  localparam int unsigned DEPTH = 16;

  logic clock;
  logic reset_n;
  int   checks;
  int   failures;

  logic [LW-1:0] seq [0:255];
  logic [LW-1:0] seq_init;
  int            seq_len;

  la_capture_ctrl_if #(.LA_WIDTH(LW), .LA_CHIPS(LC), .CNT_WIDTH(CW)) bus ();

  la_capture_ctrl #(.LA_WIDTH(LW), .LA_CHIPS(LC), .CNT_WIDTH(CW), .DEPTH(DEPTH)) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // First sample index (counted from the start) at which the trigger rule holds, or -1.
  function automatic int model_trig(input int pre, input logic [LW-1:0] tm, tv, em, er);
    logic [LW-1:0] prev;
    logic [LW-1:0] cur;
    bit ok;
    prev = seq_init;
    for (int n = 0; n < seq_len; n++) begin
      cur = seq[n];
      if (n >= pre) begin
        ok = 1'b1;
        for (int i = 0; i < int'(LW); i++) begin
          if (tm[i] && (cur[i] != tv[i])) ok = 1'b0;
          if (em[i] && er[i] && !(!prev[i] && cur[i])) ok = 1'b0;
          if (em[i] && !er[i] && !(prev[i] && !cur[i])) ok = 1'b0;
        end
        if (ok) return n;
      end
      prev = cur;
    end
    return -1;
  endfunction

  // Arms a capture and feeds seq[] one value per sample until done, max_samples, or timeout.
  task automatic drive_capture(input int pre, input int post, input logic [LW-1:0] tm, tv, em, er,
                               input int max_samples, input int poke_at,
                               output int en_cycles, output bit finished);
    @(negedge clock);
    bus.pre_samples  = CW'(pre);
    bus.post_samples = CW'(post);
    bus.trig_mask    = tm;
    bus.trig_value   = tv;
    bus.edge_mask    = em;
    bus.edge_rise    = er;
    bus.la_in        = seq_init;
    bus.start        = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    en_cycles = 0;
    finished  = 1'b0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (bus.done) begin
        finished = 1'b1;
        break;
      end
      if (en_cycles == max_samples) break;
      bus.start = (poke_at >= 0) && (en_cycles == poke_at);
      if (bus.sample_en) begin
        bus.la_in = (en_cycles < seq_len) ? seq[en_cycles] : seq[seq_len-1];
        en_cycles++;
      end
      @(negedge clock);
    end
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      bus.la_in = LW'($urandom);
    end
    checks++; if (bus.sample_en !== 1'b0) begin failures++; $display("FAIL reset_sample_en got=%b exp=0", bus.sample_en); end
    checks++; if (bus.sram_cs !== 2'b11) begin failures++; $display("FAIL reset_sram_cs got=%b exp=11", bus.sram_cs); end
    checks++; if ({bus.busy, bus.triggered, bus.done, bus.wrapped} !== 4'b0000) begin failures++;
      $display("FAIL reset_flags got=%b exp=0000", {bus.busy, bus.triggered, bus.done, bus.wrapped}); end
    checks++; if (bus.sample_index !== '0 || bus.trig_index !== '0) begin failures++;
      $display("FAIL reset_indices got=%0d/%0d exp=0/0", bus.sample_index, bus.trig_index); end
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      bus.la_in = LW'($urandom);
    end
    checks++; if (bus.sample_en !== 1'b0 || bus.sram_cs !== 2'b11) begin failures++;
      $display("FAIL idle_after_reset got en=%b cs=%b exp en=0 cs=11", bus.sample_en, bus.sram_cs); end
    checks++; if ({bus.busy, bus.triggered, bus.done, bus.wrapped} !== 4'b0000) begin failures++;
      $display("FAIL idle_flags got=%b exp=0000", {bus.busy, bus.triggered, bus.done, bus.wrapped}); end
  endtask

  task automatic test_level_trigger();
    int en; bit fin;
    seq_init = '0; seq_len = 30;
    for (int n = 0; n < seq_len; n++) seq[n] = (n >= 10) ? 8'h04 : 8'h00;
    drive_capture(4, 3, 8'h04, 8'h04, 8'h00, 8'h00, 100000, -1, en, fin);
    checks++; if (!fin) begin failures++; $display("FAIL level_done got=timeout exp=done"); end
    checks++; if (bus.trig_index !== CW'(10)) begin failures++; $display("FAIL level_trig_index got=%0d exp=10", bus.trig_index); end
    checks++; if (bus.sample_index !== CW'(14)) begin failures++; $display("FAIL level_sample_index got=%0d exp=14", bus.sample_index); end
    checks++; if (en != 14) begin failures++; $display("FAIL level_sample_cycles got=%0d exp=14", en); end
    checks++; if ({bus.done, bus.triggered, bus.busy, bus.wrapped} !== 4'b1100) begin failures++;
      $display("FAIL level_flags got=%b exp=1100", {bus.done, bus.triggered, bus.busy, bus.wrapped}); end
    checks++; if (bus.sram_cs !== 2'b11 || bus.sample_en !== 1'b0) begin failures++;
      $display("FAIL level_sram_off got cs=%b en=%b exp cs=11 en=0", bus.sram_cs, bus.sample_en); end
  endtask

  task automatic test_falling_edge();
    int en; bit fin;
    seq_init = 8'h01; seq_len = 20;
    for (int n = 0; n < seq_len; n++) seq[n] = (n < 5) ? 8'h01 : 8'h00;
    drive_capture(0, 0, 8'h00, 8'h00, 8'h01, 8'h00, 100000, -1, en, fin);
    checks++; if (!fin || bus.done !== 1'b1) begin failures++; $display("FAIL edge_done got=%b exp=1", bus.done); end
    checks++; if (bus.trig_index !== CW'(5)) begin failures++; $display("FAIL edge_trig_index got=%0d exp=5", bus.trig_index); end
    checks++; if (bus.sample_index !== CW'(6)) begin failures++; $display("FAIL edge_sample_index got=%0d exp=6", bus.sample_index); end
    checks++; if (en != 6) begin failures++; $display("FAIL edge_sample_cycles got=%0d exp=6", en); end
  endtask

  task automatic test_wrap();
    int en; bit fin;
    seq_init = '0; seq_len = 40;
    for (int n = 0; n < seq_len; n++) seq[n] = LW'($urandom);
    drive_capture(20, 2, 8'h00, 8'h00, 8'h00, 8'h00, 100000, -1, en, fin);
    checks++; if (!fin || bus.wrapped !== 1'b1) begin failures++; $display("FAIL wrap_flag got=%b exp=1", bus.wrapped); end
    checks++; if (bus.trig_index !== CW'(4)) begin failures++; $display("FAIL wrap_trig_index got=%0d exp=4", bus.trig_index); end
    checks++; if (bus.sample_index !== CW'(7)) begin failures++; $display("FAIL wrap_sample_index got=%0d exp=7", bus.sample_index); end
    checks++; if (en != 23) begin failures++; $display("FAIL wrap_sample_cycles got=%0d exp=23", en); end
  endtask

  task automatic test_abort();
    @(negedge clock);
    bus.pre_samples = CW'(2); bus.post_samples = CW'(3);
    bus.trig_mask = 8'hff; bus.trig_value = 8'haa; bus.edge_mask = '0; bus.edge_rise = '0;
    bus.la_in = '0; bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    repeat (5) @(negedge clock);
    checks++; if (bus.sample_index !== CW'(5) || bus.busy !== 1'b1) begin failures++;
      $display("FAIL abort_pre_state got idx=%0d busy=%b exp idx=5 busy=1", bus.sample_index, bus.busy); end
    bus.abort = 1'b1; bus.start = 1'b1;
    @(negedge clock);
    checks++; if (bus.sample_en !== 1'b0 || bus.sram_cs !== 2'b11) begin failures++;
      $display("FAIL abort_sram got en=%b cs=%b exp en=0 cs=11", bus.sample_en, bus.sram_cs); end
    checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin failures++;
      $display("FAIL abort_flags got busy=%b done=%b exp 0/0", bus.busy, bus.done); end
    checks++; if (bus.sample_index !== CW'(5)) begin failures++; $display("FAIL abort_index_hold got=%0d exp=5", bus.sample_index); end
    bus.abort = 1'b0; bus.start = 1'b0;
    @(negedge clock);
    checks++; if (bus.busy !== 1'b0 || bus.sample_en !== 1'b0) begin failures++;
      $display("FAIL abort_stays_idle got busy=%b en=%b exp 0/0", bus.busy, bus.sample_en); end
    bus.pre_samples = '0; bus.post_samples = '0; bus.trig_mask = '0;
    bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    checks++; if (bus.sample_index !== '0 || bus.busy !== 1'b1 || bus.sram_cs !== 2'b00) begin failures++;
      $display("FAIL rearm got idx=%0d busy=%b cs=%b exp idx=0 busy=1 cs=00", bus.sample_index, bus.busy, bus.sram_cs); end
    @(negedge clock);
    checks++; if (bus.done !== 1'b1 || bus.sample_index !== CW'(1) || bus.trig_index !== '0) begin failures++;
      $display("FAIL rearm_capture got done=%b idx=%0d trig=%0d exp 1/1/0", bus.done, bus.sample_index, bus.trig_index); end
  endtask

  task automatic test_start_during_post();
    int en; bit fin;
    seq_init = '0; seq_len = 10;
    for (int n = 0; n < seq_len; n++) seq[n] = '0;
    drive_capture(1, 5, 8'h00, 8'h00, 8'h00, 8'h00, 100000, 3, en, fin);
    checks++; if (!fin) begin failures++; $display("FAIL post_start_done got=timeout exp=done"); end
    checks++; if (en != 7) begin failures++; $display("FAIL post_start_cycles got=%0d exp=7", en); end
    checks++; if (bus.sample_index !== CW'(7) || bus.trig_index !== CW'(1)) begin failures++;
      $display("FAIL post_start_indices got=%0d/%0d exp=7/1", bus.sample_index, bus.trig_index); end
  endtask

  task automatic test_async_reset();
    @(negedge clock);
    bus.pre_samples = CW'(2); bus.post_samples = CW'(3);
    bus.trig_mask = 8'hff; bus.trig_value = 8'h55; bus.edge_mask = '0;
    bus.la_in = '0; bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    repeat (3) @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    checks++; if (bus.sample_en !== 1'b0 || bus.sram_cs !== 2'b11) begin failures++;
      $display("FAIL async_reset_sram got en=%b cs=%b exp en=0 cs=11", bus.sample_en, bus.sram_cs); end
    checks++; if (bus.sample_index !== '0 || bus.busy !== 1'b0) begin failures++;
      $display("FAIL async_reset_state got idx=%0d busy=%b exp 0/0", bus.sample_index, bus.busy); end
    @(negedge clock);
    checks++; if (bus.sample_en !== 1'b0) begin failures++; $display("FAIL async_reset_hold got=%b exp=0", bus.sample_en); end
    reset_n = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_random();
    int pre, post, k, total, en; bit fin;
    logic [LW-1:0] tm, tv, em, er, cur;
    for (int it = 0; it < 24; it++) begin
      pre  = int'($urandom_range(0, 20));
      post = int'($urandom_range(0, 10));
      tm = LW'($urandom & $urandom & $urandom);
      tv = LW'($urandom);
      em = ($urandom_range(0, 1) == 1) ? LW'(1 << $urandom_range(0, 7)) : '0;
      er = LW'($urandom);
      seq_init = LW'($urandom);
      seq_len  = pre + 30;
      cur = seq_init;
      for (int n = 0; n < seq_len; n++) begin
        cur = cur ^ LW'($urandom & $urandom);
        seq[n] = cur;
      end
      k = model_trig(pre, tm, tv, em, er);
      if (k >= 0) begin
        total = k + post + 1;
        drive_capture(pre, post, tm, tv, em, er, 100000, -1, en, fin);
        checks++; if (!fin) begin failures++; $display("FAIL rand_done it=%0d got=timeout exp=done", it); end
        checks++; if (en != total) begin failures++; $display("FAIL rand_cycles it=%0d got=%0d exp=%0d", it, en, total); end
        checks++; if (bus.trig_index !== CW'(k % DEPTH)) begin failures++;
          $display("FAIL rand_trig_index it=%0d got=%0d exp=%0d", it, bus.trig_index, k % DEPTH); end
        checks++; if (bus.sample_index !== CW'(total % DEPTH)) begin failures++;
          $display("FAIL rand_sample_index it=%0d got=%0d exp=%0d", it, bus.sample_index, total % DEPTH); end
        checks++; if (bus.wrapped !== (total >= int'(DEPTH)) || bus.triggered !== 1'b1) begin failures++;
          $display("FAIL rand_flags it=%0d got wrapped=%b trig=%b exp wrapped=%0d trig=1", it, bus.wrapped, bus.triggered, total >= int'(DEPTH)); end
      end else begin
        drive_capture(pre, post, tm, tv, em, er, seq_len, -1, en, fin);
        checks++; if (bus.busy !== 1'b1 || bus.triggered !== 1'b0) begin failures++;
          $display("FAIL rand_notrig it=%0d got busy=%b trig=%b exp 1/0", it, bus.busy, bus.triggered); end
        checks++; if (bus.sample_index !== CW'(seq_len % DEPTH)) begin failures++;
          $display("FAIL rand_notrig_index it=%0d got=%0d exp=%0d", it, bus.sample_index, seq_len % DEPTH); end
        bus.abort = 1'b1;
        @(negedge clock);
        bus.abort = 1'b0;
        checks++; if (bus.busy !== 1'b0 || bus.sample_en !== 1'b0) begin failures++;
          $display("FAIL rand_abort it=%0d got busy=%b en=%b exp 0/0", it, bus.busy, bus.sample_en); end
      end
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    reset_n = 1'b0;
    bus.start = 1'b0; bus.abort = 1'b0;
    bus.pre_samples = '0; bus.post_samples = '0;
    bus.trig_mask = '0; bus.trig_value = '0; bus.edge_mask = '0; bus.edge_rise = '0;
    bus.la_in = '0;
    test_reset();
    test_level_trigger();
    test_falling_edge();
    test_wrap();
    test_abort();
    test_start_during_post();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
